// File: rtl/fifo_ctrl_16x8_if.sv
// -----------------------------------------------------------------------------
// fifo_ctrl_16x8_if
// Bundles the producer stream, the consumer stream, the status flags and the
// asynchronous dual-port RAM port of the 16x8 FIFO controller.
//   producer : in_valid, in_ready, in_data
//   consumer : out_valid, out_ready, out_data
//   status   : count, full, almost_full, empty, overflow
//   RAM port : ram_cs, ram_rst, ram_wr_enb, ram_wr_addr, ram_wr_data,
//              ram_rd_enb, ram_rd_addr, ram_rd_data
// The master modport is the environment (producer, consumer and RAM). The
// slave modport is the controller.
// -----------------------------------------------------------------------------
interface fifo_ctrl_16x8_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic [ADDR_WIDTH:0]   count;
   logic                  full;
   logic                  almost_full;
   logic                  empty;
   logic                  overflow;
   logic                  ram_cs;
   logic                  ram_rst;
   logic                  ram_wr_enb;
   logic [ADDR_WIDTH-1:0] ram_wr_addr;
   logic [DATA_WIDTH-1:0] ram_wr_data;
   logic                  ram_rd_enb;
   logic [ADDR_WIDTH-1:0] ram_rd_addr;
   logic [DATA_WIDTH-1:0] ram_rd_data;

   modport master (
      output in_valid, in_data, out_ready, ram_rd_data,
      input  in_ready, out_valid, out_data, count, full, almost_full, empty,
             overflow, ram_cs, ram_rst, ram_wr_enb, ram_wr_addr, ram_wr_data,
             ram_rd_enb, ram_rd_addr
   );

   modport slave (
      input  in_valid, in_data, out_ready, ram_rd_data,
      output in_ready, out_valid, out_data, count, full, almost_full, empty,
             overflow, ram_cs, ram_rst, ram_wr_enb, ram_wr_addr, ram_wr_data,
             ram_rd_enb, ram_rd_addr
   );
endinterface

// File: rtl/fifo_ctrl_16x8.sv
// -----------------------------------------------------------------------------
// fifo_ctrl_16x8
// Synchronous FIFO controller that drives a 16x8 asynchronous dual-port RAM.
// It owns the write and read pointers, the RAM occupancy and the status flags.
// A first-word-fall-through output register holds the head word, so the total
// capacity is DEPTH RAM entries plus one output-register entry.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   bus  - fifo_ctrl_16x8_if.slave (streams, flags, RAM port)
// -----------------------------------------------------------------------------
module fifo_ctrl_16x8 #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int DEPTH      = 16,
   parameter int AF_LEVEL   = 12
) (
   input logic              clk,
   input logic              rst,
   fifo_ctrl_16x8_if.slave  bus
);

   localparam logic [ADDR_WIDTH:0] DEPTH_CNT = DEPTH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] AF_CNT    = AF_LEVEL[ADDR_WIDTH:0];

   logic [ADDR_WIDTH-1:0] r_wrPtr;
   logic [ADDR_WIDTH-1:0] r_rdPtr;
   logic [ADDR_WIDTH:0]   r_ramCount;
   logic                  r_outValid;
   logic [DATA_WIDTH-1:0] r_outData;
   logic                  r_overflow;

   logic                  w_inReady;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_load;
   logic                  w_ramNotEmpty;
   logic [ADDR_WIDTH:0]   w_count;

   // Handshake decode. in_ready looks only at RAM occupancy, so a pop while the
   // RAM is full frees an entry only after the load edge.
   assign w_ramNotEmpty = (r_ramCount != '0);
   assign w_inReady     = !rst && (r_ramCount < DEPTH_CNT);
   assign w_push        = bus.in_valid && w_inReady;
   assign w_pop         = r_outValid && bus.out_ready;
   assign w_load        = w_ramNotEmpty && (!r_outValid || w_pop);
   assign w_count       = r_ramCount + {{ADDR_WIDTH{1'b0}}, r_outValid};

   // The RAM reset follows the controller reset, and the chip is deselected while
   // reset is held. The read enable follows occupancy. Its rising edge makes the
   // asynchronous RAM drive a freshly written entry even when the read address has
   // not moved.
   assign bus.ram_rst     = rst;
   assign bus.ram_cs      = !rst;
   assign bus.ram_wr_enb  = w_push;
   assign bus.ram_wr_addr = r_wrPtr;
   assign bus.ram_wr_data = bus.in_data;
   assign bus.ram_rd_enb  = w_ramNotEmpty;
   assign bus.ram_rd_addr = r_rdPtr;

   // Stream outputs and status flags. All of them derive from registered state.
   assign bus.in_ready    = w_inReady;
   assign bus.out_valid   = r_outValid;
   assign bus.out_data    = r_outData;
   assign bus.count       = w_count;
   assign bus.full        = (r_ramCount == DEPTH_CNT);
   assign bus.almost_full = (w_count >= AF_CNT);
   assign bus.empty       = (w_count == '0);
   assign bus.overflow    = r_overflow;

   // The write pointer advances on every accepted word. It wraps naturally because
   // DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wrPtr <= '0;
      end else if (w_push) begin
         r_wrPtr <= r_wrPtr + 1'b1;
      end
   end

   // The output register refills from the RAM head when it is empty or being
   // popped. A pop with nothing to refill only drops valid, and the stale data
   // is left in place.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdPtr    <= '0;
         r_outValid <= 1'b0;
         r_outData  <= '0;
      end else if (w_load) begin
         r_outData  <= bus.ram_rd_data;
         r_outValid <= 1'b1;
         r_rdPtr    <= r_rdPtr + 1'b1;
      end else if (w_pop) begin
         r_outValid <= 1'b0;
      end
   end

   // RAM occupancy goes up for a write and down for a move into the output
   // register. A write and a move in the same cycle cancel each other.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ramCount <= '0;
      end else begin
         case ({w_push, w_load})
            2'b10:   r_ramCount <= r_ramCount + 1'b1;
            2'b01:   r_ramCount <= r_ramCount - 1'b1;
            default: r_ramCount <= r_ramCount;
         endcase
      end
   end

   // Any offered word that is refused sets overflow. The flag stays set until
   // the next reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_overflow <= 1'b0;
      end else if (bus.in_valid && !w_inReady) begin
         r_overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fifo_ctrl_16x8.sv
// -----------------------------------------------------------------------------
// tb_fifo_ctrl_16x8
// Directed bench for fifo_ctrl_16x8. It models the asynchronous 16x8 RAM on the
// interface and steps through the FIFO behaviour with hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_fifo_ctrl_16x8;

   logic clk;
   logic rst;
   int   testsRun;
   int   failures;

   logic [7:0] mem [16];
   logic [7:0] expQ [$];
   logic [7:0] head;

   fifo_ctrl_16x8_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

   fifo_ctrl_16x8 dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Free-running clock, 10 time units per period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Asynchronous RAM model: synchronous write, combinational read.
   always @(posedge clk) begin
      if (bus.ram_cs && bus.ram_wr_enb) mem[bus.ram_wr_addr] <= bus.ram_wr_data;
   end
   assign bus.ram_rd_data = bus.ram_rd_enb ? mem[bus.ram_rd_addr] : 8'h00;

   // Advance one clock edge, then settle just past it before driving or sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic ready);
      bus.in_valid  = valid;
      bus.in_data   = data;
      bus.out_ready = ready;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   initial begin
      testsRun = 0;
      failures = 0;
      rst = 1'b1;
      applyStimulus(1'b0, 8'h00, 1'b0);
      step();
      step();

      // While reset is held, the input is not ready, the RAM is held in reset and deselected.
      checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("rst_ram_rst", 32'(bus.ram_rst), 32'd1);
      checkOutput("rst_ram_cs", 32'(bus.ram_cs), 32'd0);
      rst = 1'b0;
      #1;
      checkOutput("reset_count", 32'(bus.count), 32'd0);
      checkOutput("reset_empty", 32'(bus.empty), 32'd1);
      checkOutput("reset_full", 32'(bus.full), 32'd0);
      checkOutput("reset_af", 32'(bus.almost_full), 32'd0);
      checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("reset_overflow", 32'(bus.overflow), 32'd0);
      checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
      checkOutput("reset_rd_enb", 32'(bus.ram_rd_enb), 32'd0);

      // Push a single word. It reaches the output register one edge later.
      applyStimulus(1'b1, 8'hA5, 1'b0);
      #1;
      checkOutput("a5_wr_enb", 32'(bus.ram_wr_enb), 32'd1);
      checkOutput("a5_wr_addr", 32'(bus.ram_wr_addr), 32'd0);
      checkOutput("a5_wr_data", 32'(bus.ram_wr_data), 32'hA5);
      step();
      applyStimulus(1'b0, 8'h00, 1'b0);
      #1;
      checkOutput("a5_rd_enb_rise", 32'(bus.ram_rd_enb), 32'd1);
      checkOutput("a5_no_bypass", 32'(bus.out_valid), 32'd0);
      step();
      checkOutput("a5_out_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("a5_out_data", 32'(bus.out_data), 32'hA5);
      checkOutput("a5_count", 32'(bus.count), 32'd1);
      checkOutput("a5_empty", 32'(bus.empty), 32'd0);
      applyStimulus(1'b0, 8'h00, 1'b1);
      step();
      applyStimulus(1'b0, 8'h00, 1'b0);
      #1;
      checkOutput("a5_drained", 32'(bus.empty), 32'd1);

      // Fill to capacity with 0x00..0x10. The pointers start at 1 for both.
      for (int i = 0; i <= 16; i++) begin
         applyStimulus(1'b1, 8'(i), 1'b0);
         #1;
         checkOutput("fill_in_ready", 32'(bus.in_ready), 32'd1);
         step();
         if (i == 10) checkOutput("af_at_11", 32'(bus.almost_full), 32'd0);
         if (i == 11) checkOutput("af_at_12", 32'(bus.almost_full), 32'd1);
      end
      applyStimulus(1'b0, 8'h00, 1'b0);
      #1;
      checkOutput("full_count", 32'(bus.count), 32'd17);
      checkOutput("full_flag", 32'(bus.full), 32'd1);
      checkOutput("full_in_ready", 32'(bus.in_ready), 32'd0);
      checkOutput("full_head", 32'(bus.out_data), 32'h00);
      checkOutput("full_overflow_clear", 32'(bus.overflow), 32'd0);

      // Offer an eighteenth word. It must be refused and must raise overflow.
      applyStimulus(1'b1, 8'hEE, 1'b0);
      #1;
      checkOutput("ovf_wr_enb", 32'(bus.ram_wr_enb), 32'd0);
      step();
      applyStimulus(1'b0, 8'h00, 1'b0);
      #1;
      checkOutput("ovf_flag", 32'(bus.overflow), 32'd1);
      checkOutput("ovf_count", 32'(bus.count), 32'd17);
      checkOutput("ovf_wr_addr", 32'(bus.ram_wr_addr), 32'd2);
      checkOutput("ovf_rd_addr", 32'(bus.ram_rd_addr), 32'd2);

      // Drain from the full state. At the boundary, in_ready recovers one cycle after the first pop.
      applyStimulus(1'b0, 8'h00, 1'b1);
      #1;
      for (int i = 0; i <= 16; i++) begin
         checkOutput("drain_valid", 32'(bus.out_valid), 32'd1);
         checkOutput("drain_data", 32'(bus.out_data), 32'(i));
         if (i == 0) checkOutput("drain_boundary_ready0", 32'(bus.in_ready), 32'd0);
         if (i == 1) checkOutput("drain_boundary_ready1", 32'(bus.in_ready), 32'd1);
         step();
      end
      applyStimulus(1'b0, 8'h00, 1'b0);
      #1;
      checkOutput("drain_empty", 32'(bus.empty), 32'd1);
      checkOutput("drain_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("drain_overflow_sticky", 32'(bus.overflow), 32'd1);

      // Preload five words 0x40..0x44, then stream 40 cycles of push plus pop.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 8'(8'h40 + i), 1'b0);
         step();
      end
      applyStimulus(1'b0, 8'h00, 1'b0);
      step();
      checkOutput("preload_count", 32'(bus.count), 32'd5);
      for (int i = 0; i < 40; i++) begin
         applyStimulus(1'b1, 8'(8'h45 + i), 1'b1);
         #1;
         checkOutput("stream_head", 32'(bus.out_data), 32'(8'h40 + i));
         checkOutput("stream_count", 32'(bus.count), 32'd5);
         step();
      end
      applyStimulus(1'b0, 8'h00, 1'b0);
      #1;
      checkOutput("stream_final_head", 32'(bus.out_data), 32'h68);
      checkOutput("stream_wr_wrap", 32'(bus.ram_wr_addr), 32'd15);
      checkOutput("stream_rd_wrap", 32'(bus.ram_rd_addr), 32'd11);

      // Raise the occupancy to nine, then reset in the middle of operation.
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 8'(8'h70 + i), 1'b0);
         step();
      end
      applyStimulus(1'b0, 8'h00, 1'b0);
      #1;
      checkOutput("pre_rst_count", 32'(bus.count), 32'd9);
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      checkOutput("mid_rst_count", 32'(bus.count), 32'd0);
      checkOutput("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
      checkOutput("mid_rst_overflow", 32'(bus.overflow), 32'd0);
      checkOutput("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
      applyStimulus(1'b1, 8'h3C, 1'b0);
      step();
      applyStimulus(1'b0, 8'h00, 1'b0);
      step();
      checkOutput("post_rst_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("post_rst_head", 32'(bus.out_data), 32'h3C);
      applyStimulus(1'b0, 8'h00, 1'b1);
      step();

      // Refill to 17 with 0x80..0x90. Then hold in_valid high while out_ready toggles.
      for (int i = 0; i <= 16; i++) begin
         applyStimulus(1'b1, 8'(8'h80 + i), 1'b0);
         expQ.push_back(8'(8'h80 + i));
         step();
      end
      for (int j = 0; j < 10; j++) begin
         applyStimulus(1'b1, 8'(8'hA0 + j), (j % 2) == 0);
         #1;
         checkOutput("bnd_count", 32'(bus.count), (j % 2) == 0 ? 32'd17 : 32'd16);
         checkOutput("bnd_in_ready", 32'(bus.in_ready), (j % 2) == 0 ? 32'd0 : 32'd1);
         if ((j % 2) == 0) begin
            head = expQ.pop_front();
            checkOutput("bnd_head", 32'(bus.out_data), 32'(head));
         end else begin
            expQ.push_back(8'(8'hA0 + j));
         end
         step();
      end

      // Drain everything and confirm exact order across the boundary phase.
      applyStimulus(1'b0, 8'h00, 1'b1);
      #1;
      checkOutput("bnd_remaining", 32'(bus.count), 32'(expQ.size()));
      while (expQ.size() > 0) begin
         head = expQ.pop_front();
         checkOutput("bnd_drain_valid", 32'(bus.out_valid), 32'd1);
         checkOutput("bnd_drain_data", 32'(bus.out_data), 32'(head));
         step();
      end
      applyStimulus(1'b0, 8'h00, 1'b0);
      #1;
      checkOutput("bnd_final_empty", 32'(bus.empty), 32'd1);

      $display("[TB] %0d tests run, %0d failed", testsRun, failures);
      $finish;
   end

endmodule

// File: doc/fifo_ctrl_16x8.md
Name: fifo_ctrl_16x8

Overview:
Synchronous FIFO controller that sits directly upstream of the 16x8 asynchronous dual-port RAM and drives all of its ports. It owns the write and read pointers, occupancy tracking and flags. It presents valid/ready streaming interfaces on both sides, with a first-word-fall-through output register. Total capacity is DEPTH RAM entries plus 1 output-register entry.

Parameters:
DATA_WIDTH, 8, data word width
ADDR_WIDTH, 4, RAM address width
DEPTH, 16, RAM entries (must equal 2**ADDR_WIDTH)
AF_LEVEL, 12, almost_full asserts when count >= AF_LEVEL

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, synchronous, active-high
in_valid  in  1  producer has data
in_ready  out  1  controller accepts data this cycle
in_data  in  DATA_WIDTH  write data
out_valid  out  1  out_data holds the FIFO head
out_ready  in  1  consumer takes the head this cycle
out_data  out  DATA_WIDTH  head word (registered)
count  out  ADDR_WIDTH+1  total occupancy, 0..DEPTH+1
full  out  1  RAM full (ram_count == DEPTH)
almost_full  out  1  count >= AF_LEVEL
empty  out  1  count == 0
overflow  out  1  sticky: push attempted while in_ready=0
ram_cs  out  1  RAM chip select
ram_rst  out  1  RAM reset
ram_wr_enb  out  1  RAM write enable
ram_wr_addr  out  ADDR_WIDTH  RAM write address
ram_wr_data  out  DATA_WIDTH  RAM write data
ram_rd_enb  out  1  RAM read enable
ram_rd_addr  out  ADDR_WIDTH  RAM read address
ram_rd_data  in  DATA_WIDTH  RAM read data (combinational)

Behaviour:
- Reset state:
  - All state is cleared by rst at the clock edge.
  - wr_ptr=0, rd_ptr=0, ram_count=0, out_valid=0, out_data=0, overflow=0.
  - Consequently count=0, empty=1, full=0, almost_full=0.
- Reset-cycle outputs:
  - ram_rst = rst (passthrough).
  - ram_cs = !rst.
  - in_ready = 0 while rst=1.
- Handshakes:
  - push = in_valid && in_ready.
  - in_ready = !rst && (ram_count < DEPTH).
  - pop = out_valid && out_ready.
- RAM write path:
  - ram_wr_enb = push, combinational.
  - ram_wr_addr = wr_ptr; ram_wr_data = in_data.
  - On push, wr_ptr increments mod DEPTH (15 -> 0).
- RAM read path:
  - ram_rd_addr = rd_ptr.
  - ram_rd_enb = (ram_count != 0), combinational.
  - ram_rd_enb must be gated by occupancy: its 0->1 transition forces the RAM to re-evaluate rd_data when rd_ptr is unchanged but the entry was newly written.
- Output register load:
  - load = (ram_count != 0) && (!out_valid || pop).
  - On load: out_data <= ram_rd_data, out_valid <= 1, rd_ptr increments mod DEPTH.
  - On pop without load: out_valid <= 0; out_data holds its last value.
- Occupancy:
  - ram_count <= ram_count + push - load.
  - Push and load in the same cycle leave ram_count unchanged.
  - count = ram_count + out_valid.
- Latency:
  - A word pushed at edge k is visible on out_data with out_valid=1 after edge k+1.
  - There is no same-cycle bypass; a write is never read in the cycle it is written.
- Ordering: strict FIFO; no word is dropped or duplicated.
- Overflow:
  - in_valid && !in_ready && !rst sets overflow=1 at the edge.
  - overflow stays set until rst.
  - The rejected word has no effect on pointers or data.
- Underflow: not possible; the consumer only sees out_valid.
- Full-boundary push/pop: with ram_count==DEPTH and a pop, in_ready stays 0 in that cycle. Load frees one entry, so in_ready=1 the following cycle.
- Reset mid-operation: all contents are discarded; the next accepted word is the next head.

Test Plan:
- Reset, then push 0xA5 for one cycle with out_ready=0 -> after the next edge out_valid=1, out_data=0xA5, count=1, empty=0; ram_rd_enb pulsed 0->1.
- Push 0x00..0x10 with out_ready=0 -> all 17 accepted. count=17, full=1, in_ready=0; almost_full=1 from count=12. An 18th in_valid sets overflow=1 while count and pointers are unchanged.
- From the full state, hold out_ready=1 -> out_data sequences 0x00..0x10, one per cycle. Then empty=1, out_valid=0; overflow remains 1.
- Preload 5 words, then push and pop every cycle for 40 cycles with an incrementing pattern -> count stays 5, order is exact, and wr_ptr/rd_ptr both wrap 15->0 at least twice.
- With count=9, assert rst for one cycle -> next cycle count=0, out_valid=0, overflow=0, in_ready=1. Push 0x3C -> 0x3C is the next head after one edge.
- Full-boundary test: hold in_valid=1 and toggle out_ready 1/0 -> exactly one word is accepted per freed RAM entry, and count never exceeds 17.
